// File: rtl/alu_disp_pkg.sv
// Shared definitions for the ALU -> seven-segment display path.
// Contents: opcode encodings, FSM state encoding, blank segment pattern,
// hex_to_seg (nibble to active-low a..g, g in bit 6), is_arith (ADD/SUB).
package alu_disp_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_ASR = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_CONV, S_SHOW} state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_bcd_display_seq_bin2bcd.sv
// bin2bcd_seq: iterative double-dabble converter, one bit per cycle.
// Ports: clk_i, rst_ni (async active-low), load_i (capture bin_i),
//        bin_i[IN_W], busy_o (conversion in progress), bcd_o[4*DIGITS].
// Loading already performs the first shift (add-3 is a no-op on an all-zero
// BCD field), so busy_o stays high for IN_W-1 further cycles and a full
// conversion spans IN_W clock edges including the load edge.
module bin2bcd_seq #(
    parameter int IN_W   = 9,
    parameter int DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [IN_W-1:0]       bin_i,
    output logic                  busy_o,
    output logic [4*DIGITS-1:0]   bcd_o
);
    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + IN_W;
    localparam int CW = $clog2(IN_W + 1);

    logic [SW-1:0] sh_q, sh_d, adj;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        adj = sh_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (sh_q[IN_W+4*k +: 4] >= 4'd5)
                adj[IN_W+4*k +: 4] = sh_q[IN_W+4*k +: 4] + 4'd3;
        end
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sh_d  = {{BW{1'b0}}, bin_i} << 1;
            cnt_d = CW'(IN_W - 1);
        end else if (cnt_q != '0) begin
            sh_d  = adj << 1;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);
    assign bcd_o  = sh_q[SW-1:IN_W];
endmodule

// File: rtl/alu_bcd_display_seq.sv
// alu_bcd_display_seq: latches signed operands + opcode on start, computes the
// result and flags, and shows it on DIGITS common-anode seven-segment digits.
// Arithmetic results appear as sign-magnitude BCD, logic/shift results as hex.
// Ports: clk, rst (async active-low), A/B[WIDTH], op[3], start,
//        busy, done (1-cycle), DISPLAYS[7*DIGITS] (active-low, digit k at
//        [7k+6:7k]), sign (active-low negative LED), zero, carry_out, overflow.
module alu_bcd_display_seq
    import alu_disp_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      A,
    input  logic [WIDTH-1:0]      B,
    input  logic [2:0]            op,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [7*DIGITS-1:0]   DISPLAYS,
    output logic                  sign,
    output logic                  zero,
    output logic                  carry_out,
    output logic                  overflow
);
    localparam int BW = 4 * DIGITS;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic             busy_q, done_q, sign_q, zero_q, carry_q, ovf_q;
    logic [BW-1:0]    dig_q;
    // flags held across the conversion
    logic             shc_q, shv_q, shz_q, shn_q;

    logic [WIDTH:0]   sa, sb, ares, amag, usum;
    logic [WIDTH-1:0] lres;
    logic             c_d, v_d, z_d, n_d, arith;
    logic             cv_busy;
    logic [BW-1:0]    cv_bcd;

    // ALU on the latched operands; arithmetic in WIDTH+1 bits never wraps,
    // so signed overflow is just the top two result bits disagreeing.
    always_comb begin
        sa    = {a_q[WIDTH-1], a_q};
        sb    = {b_q[WIDTH-1], b_q};
        usum  = {1'b0, a_q} + {1'b0, b_q};
        arith = is_arith(op_q);
        ares  = '0;
        lres  = '0;
        c_d   = 1'b0;
        case (op_q)
            OP_ADD: begin ares = sa + sb; c_d = usum[WIDTH]; end
            OP_SUB: begin ares = sa - sb; c_d = (a_q < b_q); end
            OP_AND: lres = a_q & b_q;
            OP_OR:  lres = a_q | b_q;
            OP_XOR: lres = a_q ^ b_q;
            OP_NOT: lres = ~a_q;
            OP_SHL: begin lres = {a_q[WIDTH-2:0], 1'b0};     c_d = a_q[WIDTH-1]; end
            default: begin lres = {a_q[WIDTH-1], a_q[WIDTH-1:1]}; c_d = a_q[0]; end
        endcase
        v_d  = arith & (ares[WIDTH] ^ ares[WIDTH-1]);
        n_d  = arith & ares[WIDTH];
        z_d  = arith ? (ares == '0) : (lres == '0);
        amag = ares[WIDTH] ? (~ares + 1'b1) : ares;
    end

    bin2bcd_seq #(.IN_W(WIDTH + 1), .DIGITS(DIGITS)) u_bcd (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (state_q == S_CALC && arith),
        .bin_i  (amag),
        .busy_o (cv_busy),
        .bcd_o  (cv_bcd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sign_q  <= 1'b1;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            dig_q   <= '0;
            shc_q   <= 1'b0;
            shv_q   <= 1'b0;
            shz_q   <= 1'b0;
            shn_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    a_q     <= A;
                    b_q     <= B;
                    op_q    <= op;
                    busy_q  <= 1'b1;
                    state_q <= S_CALC;
                end
                S_CALC: begin
                    shc_q <= c_d;
                    shv_q <= v_d;
                    shz_q <= z_d;
                    shn_q <= n_d;
                    if (arith) begin
                        state_q <= S_CONV;
                    end else begin
                        // hex path needs no conversion: publish straight away
                        dig_q   <= BW'(lres);
                        carry_q <= c_d;
                        ovf_q   <= 1'b0;
                        zero_q  <= z_d;
                        sign_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_SHOW;
                    end
                end
                S_CONV: if (!cv_busy) begin
                    dig_q   <= cv_bcd;
                    carry_q <= shc_q;
                    ovf_q   <= shv_q;
                    zero_q  <= shz_q;
                    sign_q  <= ~shn_q;
                    done_q  <= 1'b1;
                    state_q <= S_SHOW;
                end
                S_SHOW: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Leading-zero blanking scans from the top digit; digit 0 always lit.
    always_comb begin
        logic lit;
        lit      = ~BLANK_LZ;
        DISPLAYS = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lit = lit | (dig_q[4*k +: 4] != 4'h0) | (k == 0);
            DISPLAYS[7*k +: 7] = lit ? hex_to_seg(dig_q[4*k +: 4]) : SEG_BLANK;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sign      = sign_q;
    assign zero      = zero_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_alu_bcd_display_seq.sv
module tb_alu_bcd_display_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  A = '0, B = '0;
    logic [2:0]  op = '0;
    logic        start = 1'b0;
    logic        busy, done, sign, zero, carry_out, overflow;
    logic [27:0] DISPLAYS;

    alu_bcd_display_seq #(.WIDTH(8), .DIGITS(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .op(op), .start(start),
        .busy(busy), .done(done), .DISPLAYS(DISPLAYS), .sign(sign),
        .zero(zero), .carry_out(carry_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [27:0] disp;
        logic [3:0]  flags;   // {sign, zero, carry, ovf}
        logic [7:0]  lat;
    } res_t;

    res_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [27:0] RST_DISP = {7'h7F, 7'h7F, 7'h7F, 7'h40};

    function automatic logic [6:0] seg(input logic [3:0] h);
        case (h)
            0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
            3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
            9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
           12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
           default: return 7'b0001110;
        endcase
    endfunction

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
        res_t e;
        int ia, ib, r, mag;
        logic [7:0] lr;
        logic [3:0] d[4];
        logic s, z, c, v;
        bit lit;
        ia = int'($signed(a)); ib = int'($signed(b));
        r = 0; lr = '0; s = 1'b1; z = 1'b0; c = 1'b0; v = 1'b0;
        e = '0;
        case (o)
            3'd0: begin r = ia + ib; c = (int'(a) + int'(b)) > 255; end
            3'd1: begin r = ia - ib; c = (a < b); end
            3'd2: lr = a & b;
            3'd3: lr = a | b;
            3'd4: lr = a ^ b;
            3'd5: lr = ~a;
            3'd6: begin lr = {a[6:0], 1'b0}; c = a[7]; end
            default: begin lr = {a[7], a[7:1]}; c = a[0]; end
        endcase
        if (o < 3'd2) begin
            v = (r > 127) || (r < -128);
            s = !(r < 0);
            z = (r == 0);
            mag = (r < 0) ? -r : r;
            for (int i = 0; i < 4; i++) begin d[i] = 4'(mag % 10); mag = mag / 10; end
            e.lat = 8'd11;
        end else begin
            z = (lr == 8'h00);
            d[0] = lr[3:0]; d[1] = lr[7:4]; d[2] = 4'h0; d[3] = 4'h0;
            e.lat = 8'd2;
        end
        lit = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (d[i] != 4'h0 || i == 0) lit = 1'b1;
            e.disp[7*i +: 7] = lit ? seg(d[i]) : 7'h7F;
        end
        e.flags = {s, z, c, v};
        return e;
    endfunction

    // drives a one-cycle start; returns at the negedge after the sampling edge
    task automatic kick(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
        @(negedge clk);
        A = a; B = b; op = o; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat counts edges from the sampling edge inclusive; -1 if done never came
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, done} !== 2'b00) begin
            n_err++; $display("FAIL reset_busy_done got %b want 00", {busy, done});
        end
        n_vec++;
        if (DISPLAYS !== RST_DISP) begin
            n_err++; $display("FAIL reset_disp got %h want %h", DISPLAYS, RST_DISP);
        end
        n_vec++;
        if ({sign, zero, carry_out, overflow} !== 4'b1000) begin
            n_err++; $display("FAIL reset_flags got %b want 1000", {sign, zero, carry_out, overflow});
        end
        rst = 1'b1;
    endtask

    task automatic run_table(input string name, input logic [7:0] ta[], input logic [7:0] tb[], input logic [2:0] to[]);
        int lat;
        res_t e;
        for (int i = 0; i < ta.size(); i++) begin
            exp_q.push_back(model(ta[i], tb[i], to[i]));
            kick(ta[i], tb[i], to[i]);
            wait_done(1, lat);
            e = exp_q.pop_front();
            n_vec++;
            if (DISPLAYS !== e.disp) begin
                n_err++; $display("FAIL %s[%0d] disp got %h want %h", name, i, DISPLAYS, e.disp);
            end
            n_vec++;
            if ({sign, zero, carry_out, overflow} !== e.flags) begin
                n_err++; $display("FAIL %s[%0d] flags(s,z,c,v) got %b want %b", name, i,
                                  {sign, zero, carry_out, overflow}, e.flags);
            end
            n_vec++;
            if (lat !== int'(e.lat)) begin
                n_err++; $display("FAIL %s[%0d] latency got %0d want %0d", name, i, lat, e.lat);
            end
        end
    endtask

    task automatic test_arith();
        logic [7:0] ta[] = '{8'd100, 8'h80, 8'h80, 8'd5, 8'hC8, 8'h7F};
        logic [7:0] tb[] = '{8'd27,  8'd127, 8'h80, 8'd5, 8'd3,  8'hFF};
        logic [2:0] to[] = '{3'd0,   3'd1,   3'd0,  3'd1, 3'd0,  3'd1};
        run_table("arith", ta, tb, to);
    endtask

    task automatic test_logic();
        logic [7:0] ta[] = '{8'hA5, 8'h0F, 8'h12, 8'hFF, 8'h81, 8'h81};
        logic [7:0] tb[] = '{8'h0F, 8'hF0, 8'h40, 8'h00, 8'h00, 8'h00};
        logic [2:0] to[] = '{3'd4,  3'd2,  3'd3,  3'd5,  3'd6,  3'd7};
        run_table("logic", ta, tb, to);
    endtask

    task automatic test_random();
        logic [7:0] ta[] = new[8];
        logic [7:0] tb[] = new[8];
        logic [2:0] to[] = new[8];
        for (int i = 0; i < 8; i++) begin
            ta[i] = 8'($urandom); tb[i] = 8'($urandom); to[i] = 3'($urandom_range(0, 7));
        end
        run_table("random", ta, tb, to);
    endtask

    task automatic test_busy_ignore();
        int lat, extra;
        res_t e;
        exp_q.push_back(model(8'd100, 8'd27, 3'd0));
        kick(8'd100, 8'd27, 3'd0);
        lat = 1;
        repeat (2) begin @(negedge clk); lat++; end
        A = 8'd1; B = 8'd1; op = 3'd4; start = 1'b1;
        @(negedge clk); lat++;
        start = 1'b0;
        wait_done(lat, lat);
        e = exp_q.pop_front();
        n_vec++;
        if (lat !== int'(e.lat)) begin
            n_err++; $display("FAIL busy_ignore latency got %0d want %0d", lat, e.lat);
        end
        n_vec++;
        if (DISPLAYS !== e.disp) begin
            n_err++; $display("FAIL busy_ignore disp got %h want %h", DISPLAYS, e.disp);
        end
        extra = 0;
        repeat (20) begin @(negedge clk); if (done === 1'b1) extra++; end
        n_vec++;
        if (extra !== 0 || busy !== 1'b0) begin
            n_err++; $display("FAIL busy_ignore extra_done got %0d busy %b want 0 busy 0", extra, busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat, gap, idle;
        res_t e;
        exp_q.push_back(model(8'h3C, 8'hFF, 3'd4));
        exp_q.push_back(model(8'h3C, 8'hFF, 3'd4));
        @(negedge clk);
        A = 8'h3C; B = 8'hFF; op = 3'd4; start = 1'b1;
        @(negedge clk);
        wait_done(1, lat);
        e = exp_q.pop_front();
        n_vec++;
        if (DISPLAYS !== e.disp || lat !== int'(e.lat)) begin
            n_err++; $display("FAIL b2b_first disp %h lat %0d want %h lat %0d", DISPLAYS, lat, e.disp, e.lat);
        end
        gap = 0; idle = 0;
        do begin
            @(negedge clk);
            gap++;
            if (busy === 1'b0) idle++;
        end while (done !== 1'b1 && gap < 20);
        start = 1'b0;
        e = exp_q.pop_front();
        n_vec++;
        if (gap !== 3 || idle !== 1) begin
            n_err++; $display("FAIL b2b_gap got gap %0d idle %0d want gap 3 idle 1", gap, idle);
        end
        n_vec++;
        if (DISPLAYS !== e.disp || {sign, zero, carry_out, overflow} !== e.flags) begin
            n_err++; $display("FAIL b2b_second disp %h flags %b want %h %b", DISPLAYS,
                              {sign, zero, carry_out, overflow}, e.disp, e.flags);
        end
    endtask

    task automatic test_reset_midconv();
        int seen;
        kick(8'h80, 8'd127, 3'd1);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if ({busy, done} !== 2'b00) begin
            n_err++; $display("FAIL midconv_busy_done got %b want 00", {busy, done});
        end
        n_vec++;
        if (DISPLAYS !== RST_DISP || sign !== 1'b1) begin
            n_err++; $display("FAIL midconv_disp got %h sign %b want %h sign 1", DISPLAYS, sign, RST_DISP);
        end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (20) begin @(negedge clk); if (done === 1'b1) seen++; end
        n_vec++;
        if (seen !== 0) begin
            n_err++; $display("FAIL midconv_done_pulses got %0d want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midconv();
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_err++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_bcd_display_seq.md
Name: alu_bcd_display_seq

Overview:
- Parametrised successor to the team's 4-bit ALU-to-seven-segment display path.
- Latches signed WIDTH-bit operands and an opcode on a start pulse, then computes the result and flags.
- Arithmetic results are converted to sign-magnitude BCD by a sequential double-dabble engine; logic results are shown as hex.
- Drives DIGITS common-anode seven-segment digits plus active-low status LEDs. It sits between the board switches/buttons and the display pins.

Parameters:
- WIDTH, 8: operand width in bits (two's complement).
- DIGITS, 4: display digits. Requires 10^DIGITS > 2^WIDTH and 4*DIGITS >= WIDTH.
- BLANK_LZ, 1: 1 blanks leading zero digits; digit 0 is never blanked.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- A  in  WIDTH  signed operand A.
- B  in  WIDTH  signed operand B.
- op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 SHL A by 1, 111 ASR A by 1.
- start  in  1  request; sampled only in IDLE.
- busy  out  1  high from the start edge until the done cycle ends.
- done  out  1  one-cycle pulse when the display and flags are updated.
- DISPLAYS  out  7*DIGITS  segments, active-low; digit k uses bits [7k+6:7k] in order a..g, with g as the MSB.
- sign  out  1  active-low LED; 0 only when the op is arithmetic and the result is negative.
- zero  out  1  result == 0.
- carry_out  out  1  ADD: unsigned carry out of WIDTH bits. SUB: borrow (A<B unsigned). SHL: A[WIDTH-1]. ASR: A[0]. Otherwise 0.
- overflow  out  1  signed WIDTH-bit overflow for ADD/SUB; otherwise 0.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; busy=0, done=0.
  - zero=0, carry_out=0, overflow=0, sign=1.
  - Digit register is cleared to 0. DISPLAYS shows "0" on digit 0 (7'b1000000); the other digits show 0 if BLANK_LZ=0, otherwise they are blank (7'b1111111).
- FSM states: IDLE, CALC, CONV, SHOW.
  - IDLE: start=1 at an edge latches A, B and op, goes to CALC, and sets busy=1.
  - CALC (1 cycle):
    - Arithmetic result is computed in WIDTH+1 bits, sign-extended, so it never wraps (range -2^WIDTH .. 2^WIDTH-1, plus -2^WIDTH for ADD).
    - Flags are computed into shadow registers.
    - Arithmetic ops: the magnitude (WIDTH+1 bits unsigned) is loaded into the converter and the FSM goes to CONV.
    - Logic and shift ops: the WIDTH-bit result is zero-extended to 4*DIGITS bits as hex nibbles and the FSM goes to SHOW.
  - CONV: runs exactly WIDTH+1 shift-add-3 iterations, one per cycle, under an iteration counter, then goes to SHOW.
  - SHOW (1 cycle):
    - Digit register, flags and sign are loaded from the shadow and converter registers.
    - done=1, busy=1 during this cycle.
    - The next edge returns to IDLE with busy=0.
- Latency, counted as edges from the start-sampling edge to the first cycle with done=1: arithmetic WIDTH+3 (11 at WIDTH=8); logic 2.
- start while busy: ignored; no queueing.
- start held high: starts a new operation on the first IDLE edge after SHOW, so there is one idle cycle between operations.
- A, B and op changes during busy have no effect.
- Outputs hold their values between operations.
- Leading-zero blanking:
  - Digits above the most significant nonzero digit are blanked when BLANK_LZ=1.
  - Applies to both BCD and hex modes.
  - Blanking is combinational from the digit register.
- Hex digits A–F use the standard a..g patterns.
- Reset mid-CONV: the operation is aborted; no done pulse.

Decomposition:
- Package alu_disp_pkg:
  - opcode localparams;
  - FSM state encoding;
  - SEG_BLANK constant;
  - function hex_to_seg (4-bit to 7-bit active-low);
  - function is_arith(op).
- Sub-module bin2bcd_seq:
  - Parameters IN_W and DIGITS.
  - Ports: load, bin, busy/ready, bcd.
  - Implements the iterative double-dabble engine, instantiated once.
- ALU and flag logic stay inline in the top.

Test Plan (WIDTH=8, DIGITS=4, BLANK_LZ=1):
- Reset: assert rst=0 mid-CONV of any op → busy=0, done never pulses, DISPLAYS = {7F,7F,7F,40} (digit 3 down to digit 0), sign=1.
- ADD A=100, B=27 → done exactly 11 edges after start; digits "127" (digit 3 blank); sign=1, zero=0, carry=0, overflow=0.
- SUB A=-128 (0x80), B=127 → result -255; display "255", sign=0, overflow=1, carry_out=0.
- ADD A=-128, B=-128 → result -256; display "256", sign=0, overflow=1, carry_out=1.
- XOR A=0xA5, B=0x0F → done 2 edges after start; display "AA" (digits 3 and 2 blank), sign=1, zero=0. Then AND A=0x0F, B=0xF0 → display "0", zero=1.
- Pulse start again 3 cycles into an ADD → no restart and the done count is unchanged. Then hold start high → a second done pulse follows the first with exactly one IDLE cycle between operations.
